// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: Q4.12 limits, fixed-point angle constants, flip-flag
// bit layout and the saturating negate used when restoring quadrant signs.
package cordic_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 12;

  localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

  localparam int K_INV     = 2487;
  localparam int PI_HALF   = 6434;
  localparam int PI_CONST  = 12868;
  localparam int PI_3_HALF = 19302;
  localparam int PI_X2     = 25736;

  localparam int FLAG_W = 2;
  localparam int FLAG_X = 1;
  localparam int FLAG_Y = 0;

  // The most negative code has no positive twin, so it clamps to Q_MAX.
  function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] v);
    return (v == Q_MIN) ? Q_MAX : -v;
  endfunction

endpackage

// File: rtl/cordic_quadrant_corrector_if.sv
// Bundle of the flag-push, core-result and cos/sin output handshakes of the
// quadrant corrector; slave is the corrector side, master the surrounding logic.
interface cordic_quadrant_corrector_if #(
  parameter int DATA_W = cordic_pkg::DATA_W
);

  logic                     flag_push;
  logic                     flip_x_in;
  logic                     flip_y_in;
  logic                     flag_full;
  logic                     flag_empty;
  logic                     core_valid;
  logic signed [DATA_W-1:0] core_x;
  logic signed [DATA_W-1:0] core_y;
  logic                     core_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] cos_out;
  logic signed [DATA_W-1:0] sin_out;
  logic                     err_overflow;
  logic                     err_underflow;

  modport master (
    output flag_push, flip_x_in, flip_y_in, core_valid, core_x, core_y, out_ready,
    input  flag_full, flag_empty, core_ready, out_valid, cos_out, sin_out,
           err_overflow, err_underflow
  );

  modport slave (
    input  flag_push, flip_x_in, flip_y_in, core_valid, core_x, core_y, out_ready,
    output flag_full, flag_empty, core_ready, out_valid, cos_out, sin_out,
           err_overflow, err_underflow
  );

endinterface

// File: rtl/cordic_flag_fifo.sv
// Small synchronous FIFO holding the per-angle flip flags while angles travel
// through the CORDIC core; a push is accepted when full only if a pop frees a slot.
module cordic_flag_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPop   = pop_i && !empty_o && !flush_i;
  assign doPush  = push_i && (!full_o || doPop) && !flush_i;
  assign rdata_o = mem_q[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/cordic_quadrant_corrector.sv
// Output stage of the CORDIC rotation path: pairs each core X/Y result with its
// queued flip flags, applies saturating sign correction and registers cos/sin.
module cordic_quadrant_corrector #(
  parameter int DATA_W     = 16,
  parameter int FLAG_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  cordic_quadrant_corrector_if.slave  bus
);

  import cordic_pkg::*;

  logic [FLAG_W-1:0] flagWr;
  logic [FLAG_W-1:0] flagRd;
  logic              flagFull;
  logic              flagEmpty;
  logic              coreReady;
  logic              coreFire;
  logic              flagPop;
  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] cosOut_q, cosOut_d;
  logic [DATA_W-1:0] sinOut_q, sinOut_d;
  logic              errOvf_q, errOvf_d;
  logic              errUnf_q, errUnf_d;

  // A single output register that can reload in the same cycle it is drained.
  assign coreReady = !outValid_q || bus.out_ready;
  assign coreFire  = bus.core_valid && coreReady;
  assign flagPop   = coreFire && !flagEmpty;

  always_comb begin
    flagWr         = '0;
    flagWr[FLAG_X] = bus.flip_x_in;
    flagWr[FLAG_Y] = bus.flip_y_in;
  end

  cordic_flag_fifo #(
    .DEPTH (FLAG_DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (FLAG_W)
  ) u_flagFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (bus.flag_push),
    .pop_i   (flagPop),
    .wdata_i (flagWr),
    .rdata_o (flagRd),
    .full_o  (flagFull),
    .empty_o (flagEmpty)
  );

  // Flush drops pending work but keeps the last cos/sin and the sticky errors.
  always_comb begin
    outValid_d = outValid_q;
    cosOut_d   = cosOut_q;
    sinOut_d   = sinOut_q;
    errOvf_d   = errOvf_q;
    errUnf_d   = errUnf_q;
    if (flush) begin
      outValid_d = 1'b0;
    end else begin
      if (flagPop) begin
        outValid_d = 1'b1;
        cosOut_d   = flagRd[FLAG_X] ? sat_neg(bus.core_x) : bus.core_x;
        sinOut_d   = flagRd[FLAG_Y] ? sat_neg(bus.core_y) : bus.core_y;
      end else if (bus.out_ready) begin
        outValid_d = 1'b0;
      end
      if (coreFire && flagEmpty) errUnf_d = 1'b1;
      if (bus.flag_push && flagFull && !flagPop) errOvf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      cosOut_q   <= '0;
      sinOut_q   <= '0;
      errOvf_q   <= 1'b0;
      errUnf_q   <= 1'b0;
    end else begin
      outValid_q <= outValid_d;
      cosOut_q   <= cosOut_d;
      sinOut_q   <= sinOut_d;
      errOvf_q   <= errOvf_d;
      errUnf_q   <= errUnf_d;
    end
  end

  assign bus.core_ready    = coreReady;
  assign bus.flag_full     = flagFull;
  assign bus.flag_empty    = flagEmpty;
  assign bus.out_valid     = outValid_q;
  assign bus.cos_out       = cosOut_q;
  assign bus.sin_out       = sinOut_q;
  assign bus.err_overflow  = errOvf_q;
  assign bus.err_underflow = errUnf_q;

endmodule

// File: tb/tb_cordic_quadrant_corrector.sv
// Bench for the quadrant corrector: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based reference model.
module tb_cordic_quadrant_corrector;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  cordic_quadrant_corrector_if #(.DATA_W(16)) bus ();

  cordic_quadrant_corrector #(
    .DATA_W     (16),
    .FLAG_DEPTH (4),
    .PTR_W      (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: queued {flip_x, flip_y} pairs plus the visible output state.
  bit [1:0]    modelQ[$];
  logic        modelValid;
  logic [15:0] modelCos;
  logic [15:0] modelSin;
  logic        modelOvf;
  logic        modelUnf;

  typedef struct {
    logic        push;
    logic        fx;
    logic        fy;
    logic        cv;
    logic [15:0] cx;
    logic [15:0] cy;
    logic        ordy;
    logic        expValid;
    logic [15:0] expCos;
    logic [15:0] expSin;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input logic push, input logic fx, input logic fy,
                                 input logic cv, input logic [15:0] cx, input logic [15:0] cy,
                                 input logic ordy, input logic expValid,
                                 input logic [15:0] expCos, input logic [15:0] expSin);
    vec_t v;
    v.push = push; v.fx = fx; v.fy = fy; v.cv = cv; v.cx = cx; v.cy = cy;
    v.ordy = ordy; v.expValid = expValid; v.expCos = expCos; v.expSin = expSin;
    return v;
  endfunction

  // Negation with clamping to the largest positive Q4.12 value.
  function automatic logic [15:0] modelSatNeg(input logic [15:0] v);
    int r;
    r = -int'($signed(v));
    if (r > 32767) r = 32767;
    return 16'(r);
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelValid = 1'b0;
    modelCos   = 16'h0000;
    modelSin   = 16'h0000;
    modelOvf   = 1'b0;
    modelUnf   = 1'b0;
  endtask

  // Drives one cycle of inputs, checks core_ready, advances the model, steps the clock.
  task automatic applyStimulus(input logic push, input logic fx, input logic fy,
                               input logic cv, input logic [15:0] cx, input logic [15:0] cy,
                               input logic ordy, input logic fl);
    bit [1:0] f;
    int       sizeBefore;
    bit       ready;
    bit       fire;
    bit       popping;
    bus.flag_push  = push;
    bus.flip_x_in  = fx;
    bus.flip_y_in  = fy;
    bus.core_valid = cv;
    bus.core_x     = cx;
    bus.core_y     = cy;
    bus.out_ready  = ordy;
    flush          = fl;
    #2;
    ready = !modelValid || ordy;
    compare("core_ready", 32'(bus.core_ready), 32'(ready));
    fire       = cv && ready;
    sizeBefore = modelQ.size();
    if (fl) begin
      modelQ.delete();
      modelValid = 1'b0;
    end else begin
      popping = fire && (sizeBefore > 0);
      if (fire && sizeBefore == 0) modelUnf = 1'b1;
      if (popping) begin
        f          = modelQ.pop_front();
        modelValid = 1'b1;
        modelCos   = f[1] ? modelSatNeg(cx) : cx;
        modelSin   = f[0] ? modelSatNeg(cy) : cy;
      end else if (ordy) begin
        modelValid = 1'b0;
      end
      if (push) begin
        if (sizeBefore < 4 || popping) modelQ.push_back({fx, fy});
        else modelOvf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, " out_valid"},     32'(bus.out_valid),     32'(modelValid));
    compare({tag, " cos_out"},       {16'h0000, bus.cos_out}, {16'h0000, modelCos});
    compare({tag, " sin_out"},       {16'h0000, bus.sin_out}, {16'h0000, modelSin});
    compare({tag, " flag_empty"},    32'(bus.flag_empty),    32'(modelQ.size() == 0));
    compare({tag, " flag_full"},     32'(bus.flag_full),     32'(modelQ.size() == 4));
    compare({tag, " err_overflow"},  32'(bus.err_overflow),  32'(modelOvf));
    compare({tag, " err_underflow"}, 32'(bus.err_underflow), 32'(modelUnf));
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput(tag);
  endtask

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.flag_push  = 1'b0;
    bus.flip_x_in  = 1'b0;
    bus.flip_y_in  = 1'b0;
    bus.core_valid = 1'b0;
    bus.core_x     = '0;
    bus.core_y     = '0;
    bus.out_ready  = 1'b1;
    modelReset();

    #12;
    checkOutput("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset");

    $display("[TB] directed vector table");
    vecs.push_back(mkVec(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b1, 16'h1000, 16'h0800, 1'b1, 1'b1, 16'hF000, 16'h0800));
    vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hF000, 16'h0800));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 16'h0000));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h7FFF, 16'h0000));
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h7FFF, 16'h0000));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0100, 1'b1, 1'b1, 16'h1234, 16'hFF00));
    vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hFF00));
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFB, 16'h8000, 1'b1, 1'b1, 16'h0005, 16'h7FFF));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 16'h8000));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h7FFF, 16'h8000));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].push, vecs[i].fx, vecs[i].fy, vecs[i].cv,
                    vecs[i].cx, vecs[i].cy, vecs[i].ordy, 1'b0);
      checkOutput($sformatf("vec%0d", i));
      compare($sformatf("vec%0d table out_valid", i), 32'(bus.out_valid), 32'(vecs[i].expValid));
      compare($sformatf("vec%0d table cos_out", i), {16'h0000, bus.cos_out}, {16'h0000, vecs[i].expCos});
      compare($sformatf("vec%0d table sin_out", i), {16'h0000, bus.sin_out}, {16'h0000, vecs[i].expSin});
    end

    $display("[TB] fill, push+pop at full, overflow, stall and drain");
    for (int i = 0; i < 4; i++) begin
      bit [1:0] fl2;
      fl2 = 2'(i);
      applyStimulus(1'b1, fl2[1], fl2[0], 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      checkOutput("fill");
    end
    compare("full after fill", 32'(bus.flag_full), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0200, 16'h0300, 1'b1, 1'b0);
    checkOutput("pushpop_full");
    compare("pushpop full stays full", 32'(bus.flag_full), 32'd1);
    compare("pushpop no overflow", 32'(bus.err_overflow), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0111, 16'h0222, 1'b0, 1'b0);
    checkOutput("overflow");
    compare("overflow sticky set", 32'(bus.err_overflow), 32'd1);
    compare("stall cos held", {16'h0000, bus.cos_out}, 32'h0000_0200);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0333, 16'h0444, 1'b0, 1'b0);
    checkOutput("stall");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'(16'h0100 * (k + 1)), 16'(16'h0040 * (k + 3)), 1'b1, 1'b0);
      checkOutput($sformatf("drain%0d", k));
    end

    $display("[TB] core result with empty flag queue");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0555, 16'h0666, 1'b1, 1'b0);
    checkOutput("underflow");
    compare("underflow sticky set", 32'(bus.err_underflow), 32'd1);
    compare("underflow no out_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] flush with queued flags and a pending output");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      checkOutput("refill");
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0321, 16'h0654, 1'b0, 1'b0);
    checkOutput("pre_flush");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0777, 16'h0888, 1'b0, 1'b1);
    checkOutput("flush");
    compare("flush empties queue", 32'(bus.flag_empty), 32'd1);
    compare("flush clears out_valid", 32'(bus.out_valid), 32'd0);
    compare("flush keeps cos", {16'h0000, bus.cos_out}, 32'h0000_FCDF);
    compare("flush keeps err_overflow", 32'(bus.err_overflow), 32'd1);
    compare("flush keeps err_underflow", 32'(bus.err_underflow), 32'd1);
    idleCycle("post_flush");

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("mid_push0");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("mid_push1");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0ABC, 16'h0DEF, 1'b0, 1'b0);
    checkOutput("mid_result");
    bus.flag_push  = 1'b0;
    bus.core_valid = 1'b0;
    bus.out_ready  = 1'b1;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    compare("async reset cos", {16'h0000, bus.cos_out}, 32'h0000_0000);
    compare("async reset out_valid", 32'(bus.out_valid), 32'd0);
    compare("async reset flag_empty", 32'(bus.flag_empty), 32'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after_reset");

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      logic [15:0] rx;
      logic [15:0] ry;
      logic        rPush;
      logic        rCv;
      logic        rRdy;
      logic        rFl;
      rx = 16'($urandom);
      ry = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rx = 16'h8000;
      if ($urandom_range(0, 7) == 0) ry = 16'h8000;
      rPush = ($urandom_range(0, 1) == 1);
      rCv   = ($urandom_range(0, 1) == 1);
      rRdy  = ($urandom_range(0, 3) != 0);
      rFl   = ($urandom_range(0, 39) == 0);
      applyStimulus(rPush, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    rCv, rx, ry, rRdy, rFl);
      checkOutput($sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
